// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle sequencing controller for the RISC-V datapath.
// Fetches an instruction over a req/ack port into ir, then walks it
// through DECODE/EXEC/MEM/WB while driving the datapath selects.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        branch_taken,
  output logic [31:0] ir,
  output logic [5:0]  EXTOp,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_asel,
  output logic        alu_bsel,
  output logic        reg_we,
  output logic [1:0]  wd_sel,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [5:0] EXT_ITYPE_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_ITYPE       = 6'b010000;
  localparam logic [5:0] EXT_STYPE       = 6'b001000;
  localparam logic [5:0] EXT_BTYPE       = 6'b000100;
  localparam logic [5:0] EXT_UTYPE       = 6'b000010;
  localparam logic [5:0] EXT_JTYPE       = 6'b000001;

  localparam logic [31:0] IR_NOP = 32'h00000013;

  logic [2:0] state_nx;
  logic       is_r, is_imm, is_load, is_store, is_branch;
  logic       is_lui, is_auipc, is_jal, is_jalr, legal, rd_nz;
  logic [5:0] ext_dec;
  logic [1:0] wd_dec;
  logic       dec_valid;

  // Instruction class flags from the opcode field of ir
  always_comb begin
    is_r      = (ir[6:0] == OP_R);
    is_imm    = (ir[6:0] == OP_IMM);
    is_load   = (ir[6:0] == OP_LOAD);
    is_store  = (ir[6:0] == OP_STORE);
    is_branch = (ir[6:0] == OP_BRANCH);
    is_lui    = (ir[6:0] == OP_LUI);
    is_auipc  = (ir[6:0] == OP_AUIPC);
    is_jal    = (ir[6:0] == OP_JAL);
    is_jalr   = (ir[6:0] == OP_JALR);
    legal     = is_r | is_imm | is_load | is_store | is_branch |
                is_lui | is_auipc | is_jal | is_jalr;
    rd_nz     = (ir[11:7] != 5'd0);
  end

  // Immediate format and write-data source decoded from ir
  always_comb begin
    ext_dec = '0;
    wd_dec  = 2'b00;
    if (is_imm) begin
      ext_dec = ((ir[14:12] == 3'b001) || (ir[14:12] == 3'b101)) ? EXT_ITYPE_SHAMT : EXT_ITYPE;
    end
    if (is_load || is_jalr) ext_dec = EXT_ITYPE;
    if (is_store)           ext_dec = EXT_STYPE;
    if (is_branch)          ext_dec = EXT_BTYPE;
    if (is_lui || is_auipc) ext_dec = EXT_UTYPE;
    if (is_jal)             ext_dec = EXT_JTYPE;
    if (is_load)            wd_dec  = 2'b01;
    if (is_lui)             wd_dec  = 2'b11;
    if (is_jal || is_jalr)  wd_dec  = 2'b10;
  end

  // State register and instruction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ir    <= IR_NOP;
    end else begin
      state <= state_nx;
      if ((state == S_FETCH) && imem_ack) ir <= imem_rdata;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = S_FETCH;
      S_FETCH:  if (imem_ack) state_nx = S_DECODE;
      S_DECODE: state_nx = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_branch || is_jal)      state_nx = S_FETCH;
        else if (is_load || is_store) state_nx = S_MEM;
        else                          state_nx = S_WB;
      end
      S_MEM:    if (dmem_ack) state_nx = is_store ? S_FETCH : S_WB;
      S_WB:     state_nx = S_FETCH;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Per-cycle datapath controls from state and ir
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'b00;
    reg_we   = 1'b0;
    illegal  = 1'b0;
    EXTOp    = '0;
    alu_asel = 1'b0;
    alu_bsel = 1'b0;
    wd_sel   = 2'b00;
    dec_valid = (state == S_DECODE) || (state == S_EXEC) ||
                (state == S_MEM) || (state == S_WB);
    if (dec_valid) begin
      EXTOp    = ext_dec;
      alu_asel = is_auipc;
      alu_bsel = legal & ~is_r & ~is_branch;
      wd_sel   = wd_dec;
    end
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_EXEC: begin
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? 2'b01 : 2'b00;
        end
        if (is_jal) begin
          pc_we  = 1'b1;
          pc_sel = 2'b01;
          reg_we = rd_nz;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (is_store && dmem_ack) pc_we = 1'b1;
      end
      S_WB: begin
        reg_we = rd_nz;
        pc_we  = 1'b1;
        pc_sel = is_jalr ? 2'b10 : 2'b00;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized bench for mc_ctrl against a per-instruction
// reference model of expected selects, cycle counts and handshake counts.
module tb_mc_ctrl;

  logic        clk, rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack, branch_taken;
  logic [31:0] ir;
  logic [5:0]  EXTOp;
  logic        pc_we, alu_asel, alu_bsel, reg_we, illegal;
  logic [1:0]  pc_sel, wd_sel;
  logic [2:0]  state;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd6;

  typedef struct {
    logic        legal;
    logic [5:0]  ext;
    logic        asel, bsel, mem, store;
    int unsigned base, nreg;
    logic [1:0]  wd, pcsel;
  } exp_t;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .branch_taken(branch_taken), .ir(ir), .EXTOp(EXTOp),
    .pc_we(pc_we), .pc_sel(pc_sel), .alu_asel(alu_asel), .alu_bsel(alu_bsel),
    .reg_we(reg_we), .wd_sel(wd_sel), .illegal(illegal), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Expected behaviour of one instruction, straight from the class rules
  function automatic exp_t model(input logic [31:0] ins, input logic taken);
    exp_t e;
    int unsigned rw;
    logic [2:0] f3;
    f3 = ins[14:12];
    rw = (ins[11:7] != 5'd0) ? 1 : 0;
    e = '{legal: 1'b1, ext: 6'd0, asel: 1'b0, bsel: 1'b0, mem: 1'b0, store: 1'b0,
          base: 0, nreg: 0, wd: 2'b00, pcsel: 2'b00};
    case (ins[6:0])
      7'b0110011: begin e.base = 4; e.nreg = rw; end
      7'b0010011: begin
        e.ext = (f3 == 3'b001 || f3 == 3'b101) ? 6'b100000 : 6'b010000;
        e.bsel = 1'b1; e.base = 4; e.nreg = rw;
      end
      7'b0000011: begin e.ext = 6'b010000; e.bsel = 1'b1; e.base = 5; e.mem = 1'b1;
                        e.nreg = rw; e.wd = 2'b01; end
      7'b0100011: begin e.ext = 6'b001000; e.bsel = 1'b1; e.base = 4; e.mem = 1'b1;
                        e.store = 1'b1; end
      7'b1100011: begin e.ext = 6'b000100; e.base = 3; e.pcsel = taken ? 2'b01 : 2'b00; end
      7'b0110111: begin e.ext = 6'b000010; e.bsel = 1'b1; e.base = 4; e.nreg = rw; e.wd = 2'b11; end
      7'b0010111: begin e.ext = 6'b000010; e.asel = 1'b1; e.bsel = 1'b1; e.base = 4; e.nreg = rw; end
      7'b1101111: begin e.ext = 6'b000001; e.bsel = 1'b1; e.base = 3; e.nreg = rw;
                        e.wd = 2'b10; e.pcsel = 2'b01; end
      7'b1100111: begin e.ext = 6'b010000; e.bsel = 1'b1; e.base = 4; e.nreg = rw;
                        e.wd = 2'b10; e.pcsel = 2'b10; end
      default: e.legal = 1'b0;
    endcase
    return e;
  endfunction

  // Hold reset with imem_ack high, check the reset image, release, expect FETCH one edge later
  task automatic do_reset();
    imem_ack = 1'b1; imem_rdata = 32'h00000013; dmem_ack = 1'b0; branch_taken = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_state", {29'd0, state}, {29'd0, ST_IDLE});
    check("rst_ir", ir, 32'h00000013);
    check("rst_outs", {23'd0, imem_req, dmem_req, dmem_we, pc_we, reg_we, illegal, alu_asel, alu_bsel, EXTOp == 6'd0},
          {23'd0, 8'b0000_0000, 1'b1});
    check("rst_sel", {28'd0, pc_sel, wd_sel}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_state", {29'd0, state}, {29'd0, ST_FETCH});
  endtask

  // Run one instruction starting at a negedge where state is FETCH
  task automatic run_instr(input logic [31:0] ins, input int unsigned iwait,
                           input int unsigned dwait, input logic taken);
    exp_t e;
    int unsigned fc, dc, cyc, n_ireq, n_dreq, n_pc, n_reg, dec_bad, dwe_bad;
    logic [1:0] pcs_obs, wd_obs;
    logic [2:0] st;
    logic done;
    e = model(ins, taken);
    fc = 0; dc = 0; cyc = 0; n_ireq = 0; n_dreq = 0; n_pc = 0; n_reg = 0;
    dec_bad = 0; dwe_bad = 0; pcs_obs = 2'b00; wd_obs = 2'b00; done = 1'b0;
    check("start_fetch", {29'd0, state}, {29'd0, ST_FETCH});
    for (int k = 0; k < 200 && !done; k++) begin
      st = state;
      imem_ack     = (st == ST_FETCH) ? (fc == iwait) : 1'($urandom % 2);
      imem_rdata   = (st == ST_FETCH) ? ins : $urandom;
      dmem_ack     = (st == ST_MEM) ? (dc == dwait) : 1'($urandom % 2);
      branch_taken = (st == ST_EXEC) ? taken : 1'($urandom % 2);
      #1;
      cyc++;
      if (imem_req) n_ireq++;
      if (dmem_req) begin
        n_dreq++;
        if (dmem_we !== e.store) dwe_bad++;
      end
      if (st == ST_FETCH) fc++;
      if (st == ST_MEM) dc++;
      if (st >= ST_DECODE && st <= ST_WB) begin
        if (st == ST_DECODE && !e.legal) begin
          if ({EXTOp, alu_asel, alu_bsel, wd_sel} !== 10'd0) dec_bad++;
        end else if ({EXTOp, alu_asel, alu_bsel, wd_sel} !== {e.ext, e.asel, e.bsel, e.wd}) dec_bad++;
      end else if ({EXTOp, alu_asel, alu_bsel, wd_sel} !== 10'd0) dec_bad++;
      if (pc_we) begin n_pc++; pcs_obs = pc_sel; end
      if (reg_we) begin n_reg++; wd_obs = wd_sel; end
      if (pc_we || st == ST_TRAP) done = 1'b1;
      else @(negedge clk);
    end
    check("finished", {31'd0, done}, 32'd1);
    check("ir", ir, ins);
    check("imem_req_cycles", n_ireq, iwait + 1);
    check("decoded_selects", dec_bad, 0);
    if (e.legal) begin
      check("cycles", cyc, e.base + iwait + (e.mem ? dwait : 0));
      check("pc_we_count", n_pc, 1);
      check("pc_sel", {30'd0, pcs_obs}, {30'd0, e.pcsel});
      check("reg_we_count", n_reg, e.nreg);
      if (e.nreg == 1) check("wd_sel", {30'd0, wd_obs}, {30'd0, e.wd});
      check("dmem_req_cycles", n_dreq, e.mem ? dwait + 1 : 0);
      check("dmem_we", dwe_bad, 0);
      @(negedge clk);
    end else begin
      check("trap_state", {29'd0, state}, {29'd0, ST_TRAP});
      check("trap_no_pc", n_pc + n_reg + n_dreq, 0);
      for (int k = 0; k < 20; k++) begin
        imem_ack = 1'($urandom % 2);
        dmem_ack = 1'($urandom % 2);
        @(negedge clk);
        check("trap_hold", {27'd0, state, illegal, imem_req},
              {27'd0, ST_TRAP, 1'b1, 1'b0});
        check("trap_quiet", {29'd0, pc_we, reg_we, dmem_req}, 32'd0);
      end
      do_reset();
    end
  endtask

  initial begin
    logic [31:0] ins, r;
    logic [6:0]  op;
    logic [6:0]  ops [9];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};
    imem_ack = 1'b1; imem_rdata = 32'h00000013; dmem_ack = 1'b0;
    branch_taken = 1'b0; rst = 1'b1;
    @(negedge clk);
    do_reset();

    run_instr(32'h00500093, 2, 0, 1'b0);  // addi x1,x0,5
    run_instr(32'h00209093, 0, 0, 1'b0);  // slli
    run_instr(32'h0000a023, 1, 2, 1'b0);  // sw
    run_instr(32'hfe000ee3, 0, 0, 1'b1);  // beq taken
    run_instr(32'hfe000ee3, 0, 0, 1'b0);  // beq not taken
    run_instr(32'h0000006f, 0, 0, 1'b0);  // jal x0
    run_instr(32'h12345537, 0, 0, 1'b0);  // lui
    run_instr(32'h0000a083, 0, 0, 1'b0);  // lw x1
    run_instr(32'hffffffff, 1, 0, 1'b0);  // illegal

    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      if ($urandom % 12 == 0) begin
        op = 7'h7f;
        for (int t = 0; t < 50; t++) begin
          op = 7'($urandom);
          if (!model({25'd0, op}, 1'b0).legal) break;
        end
      end else begin
        op = ops[$urandom % 9];
      end
      ins = {r[31:7], op};
      run_instr(ins, $urandom % 4, $urandom % 4, 1'($urandom % 2));
    end

    // Reset asserted while a load waits in MEM
    for (int k = 0; k < 20 && state != ST_MEM; k++) begin
      imem_ack = (state == ST_FETCH); imem_rdata = 32'h0000a083; dmem_ack = 1'b0;
      #1;
      if (state != ST_MEM) @(negedge clk);
    end
    check("mem_reached", {29'd0, state}, {29'd0, ST_MEM});
    check("mem_req", {31'd0, dmem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("async_state", {29'd0, state}, {29'd0, ST_IDLE});
    check("async_ir", ir, 32'h00000013);
    check("async_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    do_reset();
    run_instr(32'h00500093, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
